costas_bpsk_loop: RTL

- Parametrised BPSK Costas carrier-recovery loop. Generalises the fixed 8-bit / IP-core loop.
- Contains an internal phase-accumulator NCO with a hard-limited (sign) mixer, and integrate-and-dump arm filters.
- Contains a PI loop filter with gain switching between acquisition and tracking, and a lock-detector FSM.
- Sits between the ADC sample stream and the symbol-timing/decision stage.

---
 rtl/costas_bpsk_loop.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/costas_bpsk_loop.sv
// BPSK Costas carrier-recovery loop: sign-mixer NCO, integrate-and-dump arms,
// gain-switched PI loop filter and a consecutive-dump lock detector.
module costas_bpsk_loop #(
  parameter int unsigned DW         = 8,
  parameter int unsigned PW         = 32,
  parameter int unsigned DUMP_LEN   = 16,
  parameter int unsigned KP_ACQ     = 4,
  parameter int unsigned KI_ACQ     = 10,
  parameter int unsigned KP_TRK     = 6,
  parameter int unsigned KI_TRK     = 14,
  parameter int unsigned LOCK_SHIFT = 1,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_CNT = 8,
  localparam int unsigned AW        = DW + 1 + $clog2(DUMP_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic [PW-1:0] freq_word,
  output logic [AW-1:0] di,
  output logic [AW-1:0] dq,
  output logic          dout_valid,
  output logic [PW-1:0] df,
  output logic          locked
);

  localparam int unsigned CW  = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam int unsigned MW  = DW + 1;
  localparam int unsigned PDW = AW + 1;
  localparam int unsigned SW  = ((PW > PDW) ? PW : PDW) + 2;
  localparam int unsigned LW  = AW + LOCK_SHIFT + 1;
  localparam int unsigned GW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW  = $clog2(UNLOCK_CNT + 1);

  localparam logic signed [SW-1:0] SatHi = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [SW-1:0] SatLo = {{(SW-PW+1){1'b1}}, {(PW-1){1'b0}}};

  typedef enum logic [0:0] {StAcq, StLock} state_e;

  function automatic logic signed [PW-1:0] sat_pw(input logic signed [SW-1:0] x);
    if (x > SatHi) begin
      return {1'b0, {(PW-1){1'b1}}};
    end else if (x < SatLo) begin
      return {1'b1, {(PW-1){1'b0}}};
    end
    return x[PW-1:0];
  endfunction

  // NCO and hard-limited mixer
  logic        [PW-1:0] phase_q;
  logic        [1:0]    quad;
  logic                 csign_neg, ssign_neg;
  logic signed [MW-1:0] din_x, mi_d, mq_d, mi_q, mq_q;
  logic                 mix_vld_q;
  logic signed [PW-1:0] df_q, integ_q;

  assign quad      = phase_q[PW-1 -: 2];
  assign csign_neg = quad[1] ^ quad[0];
  assign ssign_neg = quad[1];
  // One extra bit so negating the most negative sample stays exact
  assign din_x     = {din[DW-1], din};
  assign mi_d      = csign_neg ? -din_x : din_x;
  assign mq_d      = ssign_neg ? -din_x : din_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      mi_q      <= '0;
      mq_q      <= '0;
      mix_vld_q <= 1'b0;
    end else begin
      mix_vld_q <= din_valid;
      if (din_valid) begin
        phase_q <= phase_q + freq_word + df_q;
        mi_q    <= mi_d;
        mq_q    <= mq_d;
      end
    end
  end

  // Integrate-and-dump arms
  logic signed [AW-1:0] mi_x, mq_x, ai_q, aq_q, ai_sum, aq_sum, di_q, dq_q;
  logic        [CW-1:0] cnt_q;
  logic                 dout_valid_q;

  assign mi_x   = AW'(mi_q);
  assign mq_x   = AW'(mq_q);
  assign ai_sum = ai_q + mi_x;
  assign aq_sum = aq_q + mq_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_q         <= '0;
      aq_q         <= '0;
      cnt_q        <= '0;
      di_q         <= '0;
      dq_q         <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (mix_vld_q) begin
        if (cnt_q == CW'(DUMP_LEN - 1)) begin
          // Dump includes the current product; the next period starts from zero
          di_q         <= ai_sum;
          dq_q         <= aq_sum;
          dout_valid_q <= 1'b1;
          ai_q         <= '0;
          aq_q         <= '0;
          cnt_q        <= '0;
        end else begin
          ai_q  <= ai_sum;
          aq_q  <= aq_sum;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // Phase detector and PI loop filter
  state_e               state_q, state_d;
  logic signed [PDW-1:0] dq_p, pd;
  logic signed [SW-1:0]  pd_x, integ_sum, df_sum;
  logic signed [PW-1:0]  integ_new, df_new;
  int unsigned           kp_sel, ki_sel;

  assign dq_p = PDW'(dq_q);
  assign pd   = di_q[AW-1] ? -dq_p : dq_p;
  assign pd_x = SW'(pd);

  always_comb begin
    kp_sel    = KP_ACQ;
    ki_sel    = KI_ACQ;
    if (state_q == StLock) begin
      kp_sel = KP_TRK;
      ki_sel = KI_TRK;
    end
    integ_sum = SW'(integ_q) + (pd_x >>> ki_sel);
    integ_new = sat_pw(integ_sum);
    df_sum    = SW'(integ_new) + (pd_x >>> kp_sel);
    df_new    = sat_pw(df_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      df_q    <= '0;
    end else if (dout_valid_q) begin
      integ_q <= integ_new;
      df_q    <= df_new;
    end
  end

  // Lock detector
  logic signed [LW-1:0] di_l, dq_l;
  logic        [LW-1:0] mag_i, mag_q;
  logic                 good;
  logic        [GW-1:0] gcnt_q, gcnt_d;
  logic        [BW-1:0] bcnt_q, bcnt_d;
  logic                 locked_q, locked_d;

  assign di_l  = LW'(di_q);
  assign dq_l  = LW'(dq_q);
  assign mag_i = di_l[LW-1] ? -di_l : di_l;
  assign mag_q = dq_l[LW-1] ? -dq_l : dq_l;
  assign good  = mag_i > (mag_q << LOCK_SHIFT);

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    bcnt_d   = bcnt_q;
    locked_d = locked_q;
    if (dout_valid_q) begin
      case (state_q)
        StAcq: begin
          if (!good) begin
            gcnt_d = '0;
          end else if (gcnt_q == GW'(LOCK_CNT - 1)) begin
            state_d  = StLock;
            locked_d = 1'b1;
            gcnt_d   = '0;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        StLock: begin
          if (good) begin
            bcnt_d = '0;
          end else if (bcnt_q == BW'(UNLOCK_CNT - 1)) begin
            // Integrator is kept so reacquisition starts from the last estimate
            state_d  = StAcq;
            locked_d = 1'b0;
            bcnt_d   = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        default: begin
          state_d  = StAcq;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAcq;
      gcnt_q   <= '0;
      bcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      bcnt_q   <= bcnt_d;
      locked_q <= locked_d;
    end
  end

  assign di         = di_q;
  assign dq         = dq_q;
  assign dout_valid = dout_valid_q;
  assign df         = df_q;
  assign locked     = locked_q;

endmodule
